// File: rtl/mips_regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// mips_rf_pkg
// Shared constants and helpers for the MIPS register file / scoreboard slice.
//   DEF_DATA_W  default register width
//   DEF_ADDR_W  default register address width (depth = 2**ADDR_W)
//   ZERO_REG    architectural zero register index
//   slice_lsb() LSB position of port N inside a packed multi-port bus
// Optional feature macro used by this slice: RF_BYPASS_EN (see top module).
// ---------------------------------------------------------------------------
package mips_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // Read ports are packed side by side: port i occupies [i*width +: width].
    function automatic int slice_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/mips_regfile_sb_if.sv
// ---------------------------------------------------------------------------
// mips_regfile_sb_if
// Bundle between the decode/issue FSM + writeback mux (master) and the
// register file with scoreboard (slave).
//   rd_addr   NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD*DATA_W  read data, packed the same way
//   rd_busy   NUM_RD         pending bit of each addressed register
//   wr_en/wr_addr/wr_data    writeback port
//   issue_en/issue_addr      request to mark a destination pending
//   issue_ok                 issue accepted this cycle (combinational)
//   flush                    clear all pending bits
//   busy_cnt  ADDR_W+1       number of pending registers
//
// Issue handshake: issue_en acts as valid and issue_ok as ready. The issue
// is taken on a rising clk edge only when both are high in the same cycle;
// issue_ok may depend combinationally on issue_addr and the writeback port,
// and the master holds issue_addr stable while issue_en is high.
// Optional feature macro used by this slice: RF_BYPASS_EN.
// ---------------------------------------------------------------------------
interface mips_regfile_sb_if
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ok;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rd_busy, issue_ok, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rd_busy, issue_ok, busy_cnt
    );

endinterface

// File: rtl/mips_regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Busy-bit scoreboard: one pending bit per architectural register plus an
// incrementally maintained population count.
//   clk, rst       clock, asynchronous active-high reset
//   issue_en_i     issue request, issue_addr_i = destination register
//   wr_en_i        writeback strobe, wr_addr_i = retiring register
//   flush_i        squash: clear every pending bit
//   busy_o         registered busy vector (bit 0 is always 0)
//   issue_ok_o     issue may be accepted this cycle (combinational)
//   busy_cnt_o     number of set busy bits
// ---------------------------------------------------------------------------
module rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_en_i,
    input  logic [ADDR_W-1:0]      issue_addr_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic                   flush_i,
    output logic [(2**ADDR_W)-1:0] busy_o,
    output logic                   issue_ok_o,
    output logic [ADDR_W:0]        busy_cnt_o
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_w, clr_w;

    // A busy destination blocks a new producer (WAW) unless the older
    // producer retires through writeback in this very cycle.
    assign issue_ok_o = (issue_addr_i == ZERO_ADDR) ||
                        !busy_q[issue_addr_i] ||
                        (wr_en_i && (wr_addr_i == issue_addr_i));

    always_comb begin
        set_w  = issue_en_i && issue_ok_o && (issue_addr_i != ZERO_ADDR);
        clr_w  = wr_en_i && (wr_addr_i != ZERO_ADDR) && busy_q[wr_addr_i];
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            // Clear before set so that on the same address the new producer
            // wins and the bit stays 1.
            if (clr_w) busy_d[wr_addr_i]    = 1'b0;
            if (set_w) busy_d[issue_addr_i] = 1'b1;
            // Same-address set+clear nets to zero; the count only moves
            // when exactly one of the two happens.
            if (set_w && !clr_w)      cnt_d = cnt_q + CNT_W'(1);
            else if (!set_w && clr_w) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// ---------------------------------------------------------------------------
// mips_regfile_sb
// General-purpose register file for the multi-cycle MIPS datapath with an
// integrated busy-bit scoreboard for RAW/WAW stall decisions.
//   clk, rst   clock, asynchronous active-high reset
//   sb         mips_regfile_sb_if.slave: NUM_RD asynchronous read ports,
//              one synchronous writeback port, issue/flush scoreboard port
// Register 0 reads as zero and is never written.
//
// Build option RF_BYPASS_EN: when defined, a read of the register being
// written back in the same cycle returns wr_data and reports not-busy.
// When undefined, reads return the stored (pre-edge) value and the
// registered busy bit.
// ---------------------------------------------------------------------------
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                clk,
    input  logic                rst,
    mips_regfile_sb_if.slave    sb
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_w;
    logic              wr_go;

    assign wr_go = sb.wr_en && (sb.wr_addr != ZERO_ADDR);

    // Entry 0 is cleared by reset and never targeted by a write, so it
    // stays zero; the read mux also forces address 0 to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_go) begin
            regs_q[sb.wr_addr] <= sb.wr_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_en_i   (sb.issue_en),
        .issue_addr_i (sb.issue_addr),
        .wr_en_i      (sb.wr_en),
        .wr_addr_i    (sb.wr_addr),
        .flush_i      (sb.flush),
        .busy_o       (busy_w),
        .issue_ok_o   (sb.issue_ok),
        .busy_cnt_o   (sb.busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = sb.rd_addr[slice_lsb(i, ADDR_W) +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            busy = busy_w[addr];
`ifdef RF_BYPASS_EN
            // Same-cycle forwarding of the retiring value.
            if (wr_go && (sb.wr_addr == addr)) begin
                data = sb.wr_data;
                busy = 1'b0;
            end
`endif
            // Outputs are held at zero for the whole reset pulse, including
            // any bypass path that is still being driven.
            if (rst || (addr == ZERO_ADDR)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign sb.rd_data[slice_lsb(i, DATA_W) +: DATA_W] = data;
        assign sb.rd_busy[i]                              = busy;
    end

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
Parametrised general-purpose register file with an integrated busy-bit scoreboard for the multi-cycle MIPS datapath.
- Provides NUM_RD asynchronous read ports and one synchronous write (writeback) port; register 0 is hardwired to zero.
- Tracks pending destination registers between issue and writeback, so control can stall on RAW and WAW hazards.
- Sits between the decode/issue FSM and the writeback mux.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, packed the same way
rd_busy  out  NUM_RD  busy bit of each addressed register
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
issue_en  in  1  request to mark a destination register pending
issue_addr  in  ADDR_W  destination register of the issuing instruction
issue_ok  out  1  issue is accepted this cycle (combinational)
flush  in  1  clear all pending bits (exception/branch squash)
busy_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - all registers = 0
  - all busy bits = 0
  - busy_cnt = 0
  - rd_data = 0, rd_busy = 0, issue_ok = 1 while rst is high
- Read:
  - combinational: rd_data[i] = Reg[rd_addr[i]]
  - address 0 always returns 0 with rd_busy = 0
- Write:
  - on posedge clk, if wr_en && wr_addr != 0, Reg[wr_addr] <= wr_data
  - writes to address 0 are ignored; Reg[0] is never stored
- Scoreboard issue_ok:
  - issue_ok = (issue_addr == 0) || !busy[issue_addr] || (wr_en && wr_addr == issue_addr)
  - i.e. WAW stall unless the same-cycle writeback retires the older producer
- Scoreboard updates, at posedge, in priority order:
  - flush: all busy <= 0, busy_cnt <= 0; issue and clear are ignored that cycle; the register write still occurs
  - otherwise set = issue_en && issue_ok && issue_addr != 0
  - clear = wr_en && wr_addr != 0 && busy[wr_addr]
  - same address for set and clear: busy stays 1 (new producer wins) and busy_cnt is unchanged
  - different addresses: apply both; busy_cnt += set - clear
  - writeback to a non-busy register: data is written, busy is unaffected, no counter change
- busy_cnt:
  - always equals the popcount of the busy vector
  - maintained incrementally; never wraps (max 2**ADDR_W - 1)
- Latency:
  - write visible on reads the cycle after the edge (without bypass)
  - busy changes visible on rd_busy / issue_ok the cycle after the edge

Optional Feature:
RF_BYPASS_EN
- Defined:
  - when wr_en && wr_addr == rd_addr[i] && rd_addr[i] != 0, rd_data[i] = wr_data
  - rd_busy[i] = 0 in the same cycle, giving same-cycle write-to-read forwarding
- Undefined:
  - reads return the pre-edge register value
  - rd_busy reflects the registered busy bit only

Decomposition:
- Package mips_rf_pkg holds:
  - default DATA_W/ADDR_W constants
  - ZERO_REG address constant
  - a function for packed port slicing
- One sub-module: rf_scoreboard, containing:
  - busy vector, busy_cnt, issue_ok logic and flush handling
  - parametrised by ADDR_W
- The storage array and read muxes stay in the top module.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Write 0xDEADBEEF to r5, then read r5 next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
- Issue r7, then issue r7 again -> second issue_ok = 0; writeback r7 (0xA5A5A5A5) together with re-issue of r7 -> issue_ok = 1, busy[r7] stays 1, busy_cnt stays 1.
- Issue r1, r2, r3 on successive cycles, then flush together with issue r4 -> busy_cnt goes 1, 2, 3, then 0; r4 not busy.
- Assert rst mid-sequence with busy_cnt = 2 and r9 = 0x55 -> immediately busy_cnt = 0 and r9 = 0, without waiting for a clock edge.
- With RF_BYPASS_EN, wr r12 = 0xCAFE while rd_addr[0] = 12 in the same cycle -> rd_data[0] = 0xCAFE, rd_busy[0] = 0; without the macro -> old value.
